// File: rtl/wf_button_events.sv
// wf_button_events -- multi-channel push-button front end.
//
// Turns raw asynchronous switch pins into debounced levels and one-cycle
// event pulses (press, release, long press, auto-repeat). A built-in
// prescaler produces the shared sample strobe; each channel has a
// SAMPLES-deep agreement filter and a small IDLE/DOWN/HELD hold machine.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   sw_in         raw switch pins (polarity set by ACTIVE_LOW)
//   tick          one-cycle sample strobe, exported for sharing
//   level         debounced state, 1 = pushed
//   pushed        one-cycle pulse on debounced press
//   released      one-cycle pulse on debounced release
//   long_press    one-cycle pulse when a hold reaches LONG_TICKS
//   repeat_pulse  one-cycle auto-repeat pulse every REPEAT_TICKS past long
//                 press ('repeat' itself is a reserved word)
module wf_button_events #(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 160000,
  parameter int SAMPLES      = 3,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sw_in,
  output logic                tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pushed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0]   LONG_C   = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0]   REPEAT_C = HOLD_W'(REPEAT_TICKS);
  localparam logic [HOLD_W-1:0]   HOLD_SAT = {HOLD_W{1'b1}};
  // Synchroniser reset value is the pin level of a released button.
  localparam logic [CHANNELS-1:0] IDLE_PIN = ACTIVE_LOW ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  logic [CHANNELS-1:0] sync1_r, sync2_r;
  logic [DIV_W-1:0]    div_cnt_r, div_nxt_s;
  logic [SAMPLES-2:0]  hist_r    [CHANNELS];
  logic [SAMPLES-1:0]  win_s     [CHANNELS];
  logic [HOLD_W-1:0]   cnt_r     [CHANNELS];
  logic [HOLD_W-1:0]   cnt_inc_s [CHANNELS];
  state_t              state_r   [CHANNELS];
  logic [CHANNELS-1:0] sample_s, rise_s, fall_s;

  // Two-flop synchroniser per pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= IDLE_PIN;
      sync2_r <= IDLE_PIN;
    end else begin
      sync1_r <= sw_in;
      sync2_r <= sync1_r;
    end
  end

  // Next prescaler count, wrapping at TICK_DIV-1.
  always_comb begin
    div_nxt_s = {DIV_W{1'b0}};
    if (div_cnt_r == DIV_LAST) begin
      div_nxt_s = {DIV_W{1'b0}};
    end else begin
      div_nxt_s = div_cnt_r + DIV_W'(1);
    end
  end

  // Prescaler; tick is registered so it is high while the count sits at TICK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      tick      <= 1'b0;
    end else begin
      div_cnt_r <= div_nxt_s;
      tick      <= (div_nxt_s == DIV_LAST);
    end
  end

  // Per-channel sample window (history plus new sample), level edges, counter increment.
  always_comb begin
    sample_s = ACTIVE_LOW ? ~sync2_r : sync2_r;
    rise_s   = {CHANNELS{1'b0}};
    fall_s   = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      win_s[c]     = {hist_r[c], sample_s[c]};
      rise_s[c]    = tick & (&win_s[c]) & ~level[c];
      fall_s[c]    = tick & ~(|win_s[c]) & level[c];
      cnt_inc_s[c] = cnt_r[c] + HOLD_W'(1);
    end
  end

  // Agreement filter: history shifts on tick, level follows unanimous windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= {CHANNELS{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
        hist_r[c] <= {(SAMPLES-1){1'b0}};
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (tick) begin
          hist_r[c] <= win_s[c][SAMPLES-2:0];
        end else begin
          hist_r[c] <= hist_r[c];
        end
        if (rise_s[c]) begin
          level[c] <= 1'b1;
        end else if (fall_s[c]) begin
          level[c] <= 1'b0;
        end else begin
          level[c] <= level[c];
        end
      end
    end
  end

  // Hold state machine per channel with registered event pulses.
  // A fall is tested before any threshold so a release on the same tick wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pushed       <= {CHANNELS{1'b0}};
      released     <= {CHANNELS{1'b0}};
      long_press   <= {CHANNELS{1'b0}};
      repeat_pulse <= {CHANNELS{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
        state_r[c] <= ST_IDLE;
        cnt_r[c]   <= {HOLD_W{1'b0}};
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        pushed[c]       <= 1'b0;
        released[c]     <= 1'b0;
        long_press[c]   <= 1'b0;
        repeat_pulse[c] <= 1'b0;
        case (state_r[c])
          ST_IDLE: begin
            if (rise_s[c]) begin
              pushed[c]  <= 1'b1;
              cnt_r[c]   <= {HOLD_W{1'b0}};
              state_r[c] <= ST_DOWN;
            end else begin
              state_r[c] <= ST_IDLE;
            end
          end
          ST_DOWN: begin
            if (fall_s[c]) begin
              released[c] <= 1'b1;
              cnt_r[c]    <= {HOLD_W{1'b0}};
              state_r[c]  <= ST_IDLE;
            end else if (tick) begin
              if (cnt_inc_s[c] == LONG_C) begin
                long_press[c] <= 1'b1;
                cnt_r[c]      <= {HOLD_W{1'b0}};
                state_r[c]    <= ST_HELD;
              end else begin
                cnt_r[c] <= cnt_inc_s[c];
              end
            end else begin
              cnt_r[c] <= cnt_r[c];
            end
          end
          ST_HELD: begin
            if (fall_s[c]) begin
              released[c] <= 1'b1;
              cnt_r[c]    <= {HOLD_W{1'b0}};
              state_r[c]  <= ST_IDLE;
            end else if (tick) begin
              if ((REPEAT_TICKS != 0) && (cnt_inc_s[c] == REPEAT_C)) begin
                repeat_pulse[c] <= 1'b1;
                cnt_r[c]        <= {HOLD_W{1'b0}};
              end else if (cnt_r[c] != HOLD_SAT) begin
                cnt_r[c] <= cnt_inc_s[c];
              end else begin
                cnt_r[c] <= cnt_r[c];
              end
            end else begin
              cnt_r[c] <= cnt_r[c];
            end
          end
          default: begin
            cnt_r[c]   <= {HOLD_W{1'b0}};
            state_r[c] <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wf_button_events.sv
// Directed self-checking bench for wf_button_events (2 channels, 4-cycle tick,
// 3-sample filter, long press after 5 ticks, repeat every 2 ticks, active-low pins).
module tb_wf_button_events;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw_in;
  logic       tick;
  logic [1:0] level, pushed, released, long_press, repeat_pulse;

  int cyc;
  int n_checks = 0;
  int n_pass   = 0;

  wf_button_events #(
    .CHANNELS(2), .TICK_DIV(4), .SAMPLES(3),
    .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .tick(tick), .level(level),
    .pushed(pushed), .released(released), .long_press(long_press),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  // Edges since reset release; tick is expected high when cyc % 4 == 3.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to just after the edge that consumes the next tick.
  task automatic to_tick_edge();
    do step(); while (cyc % 4 != 0);
  endtask

  // At the next tick edge check level and events, then check all pulses drop a cycle later.
  task automatic expect_tick(input string tag, input logic [1:0] lvl, input logic [1:0] psh,
                             input logic [1:0] rel, input logic [1:0] lng, input logic [1:0] rpt);
    to_tick_edge();
    check_eq({tag, ".level"}, {14'd0, level}, {14'd0, lvl});
    check_eq({tag, ".events"}, {8'd0, pushed, released, long_press, repeat_pulse},
             {8'd0, psh, rel, lng, rpt});
    step();
    check_eq({tag, ".width"}, {8'd0, pushed, released, long_press, repeat_pulse}, 16'd0);
  endtask

  logic quiet, tick_bad;

  initial begin
    rst   = 1'b1;
    sw_in = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.outputs", {6'd0, tick, level, pushed, released, long_press, repeat_pulse}, 16'd0);
    @(negedge clk) rst = 1'b0;

    // 1: clean press then release on channel 0.
    to_tick_edge();
    sw_in[0] = 1'b0;
    expect_tick("s1.t1", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s1.t2", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s1.t3", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    sw_in[0] = 1'b1;
    expect_tick("s1.t4", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s1.t5", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s1.t6", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);

    // 2: bounce every 5 cycles; a 4-cycle tick never sees 3 equal pressed samples.
    quiet    = 1'b0;
    tick_bad = 1'b0;
    for (int i = 0; i < 76; i++) begin
      if (i < 60 && i % 5 == 0) sw_in[0] = ~sw_in[0];
      if (i == 60) sw_in[0] = 1'b1;
      step();
      quiet    = quiet | level[0] | pushed[0] | released[0];
      tick_bad = tick_bad | (tick !== (cyc % 4 == 3));
    end
    check_eq("s2.bounce_quiet", {15'd0, quiet}, 16'd0);
    check_eq("s2.tick_period", {15'd0, tick_bad}, 16'd0);

    // 3: long hold; long at T0+5, repeats at T0+7,9,11,13; release sampled from T0+13.
    to_tick_edge();
    sw_in[0] = 1'b0;
    expect_tick("s3.p1", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s3.p2", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s3.p3", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 15; k++) begin
      expect_tick($sformatf("s3.k%0d", k),
                  (k < 15) ? 2'b01 : 2'b00, 2'b00,
                  (k == 15) ? 2'b01 : 2'b00,
                  (k == 5) ? 2'b01 : 2'b00,
                  (k == 7 || k == 9 || k == 11 || k == 13) ? 2'b01 : 2'b00);
      if (k == 12) sw_in[0] = 1'b1;
    end

    // 4: level falls on exactly T0+5; release wins over long press.
    to_tick_edge();
    sw_in[0] = 1'b0;
    expect_tick("s4.p1", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s4.p2", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s4.p3", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    expect_tick("s4.k1", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s4.k2", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    sw_in[0] = 1'b1;
    expect_tick("s4.k3", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s4.k4", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s4.k5", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    expect_tick("s4.k6", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // 5: channel 1 pressed two ticks after channel 0, both released together.
    to_tick_edge();
    sw_in[0] = 1'b0;
    expect_tick("s5.e1", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s5.e2", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    sw_in[1] = 1'b0;
    expect_tick("s5.e3", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    expect_tick("s5.e4", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s5.e5", 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
    sw_in = 2'b11;
    expect_tick("s5.e6", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s5.e7", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    // Channel 0 is at T0+5 here; the shared release wins.
    expect_tick("s5.e8", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);

    // 6: asynchronous reset while channel 0 repeats, pin kept pressed.
    to_tick_edge();
    sw_in[0] = 1'b0;
    expect_tick("s6.p1", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s6.p2", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s6.p3", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      expect_tick($sformatf("s6.k%0d", k), 2'b01, 2'b00, 2'b00,
                  (k == 5) ? 2'b01 : 2'b00, (k == 7) ? 2'b01 : 2'b00);
    end
    to_tick_edge();
    check_eq("s6.k9_repeat", {14'd0, repeat_pulse}, 16'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("s6.async_clear", {6'd0, tick, level, pushed, released, long_press, repeat_pulse}, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    expect_tick("s6.r1", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s6.r2", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_tick("s6.r3", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      expect_tick($sformatf("s6.h%0d", k), 2'b01, 2'b00, 2'b00,
                  (k == 5) ? 2'b01 : 2'b00, 2'b00);
    end
    sw_in[0] = 1'b1;
    repeat (4) to_tick_edge();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
